pipe_ctrl_chain: RTL

//  Parametrised instruction pipeline controller. It generalises the fixed IR1..IR4 / PC1..PC3 register chain
//  to DEPTH stages, each carrying {valid, instr, pc, dst, wr}. Adds RAW-hazard interlock, branch flush,

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pipe_stage_reg.sv | 34 +++
 rtl/pipe_ctrl_chain.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the instruction pipeline controller: stage payload and stage actions.
// Payload field widths are fixed here and used by every file of the block.
package pipe_pkg;

    localparam int unsigned INSTR_W     = 8;
    localparam int unsigned PC_W        = 8;
    localparam int unsigned REG_AW      = 2;
    localparam logic [3:0]  STOP_OP_DEF = 4'h1;

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [REG_AW-1:0]  dst;
        logic               wr;
    } stage_t;

    // Per-stage action in falling priority of effect: keep, insert bubble, take upstream.
    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_LOAD   = 2'd2
    } stage_act_e;

    function automatic logic act_loads(input stage_act_e act);
        return act != ACT_HOLD;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register: holds, takes its upstream payload, or clears to a bubble.
module pipe_stage_reg
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  stage_act_e act,
    input  stage_t     d,
    output stage_t     q
);

    stage_t stage_q;
    stage_t stage_d;

    always_comb begin
        stage_d = stage_q;
        case (act)
            ACT_LOAD:   stage_d = d;
            ACT_BUBBLE: stage_d = '0;
            default:    stage_d = stage_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q;

endmodule

// File: rtl/pipe_ctrl_chain.sv
// DEPTH-stage instruction pipeline controller with RAW interlock, flush, hold and sticky halt.
// Define PIPE_PERF_EN to build the saturating performance counters; otherwise perf_* read 0.
module pipe_ctrl_chain
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned BR_STAGE = 2,
    parameter logic [3:0]  STOP_OP  = STOP_OP_DEF
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       fetch_valid,
    input  logic [INSTR_W-1:0]         fetch_instr,
    input  logic [PC_W-1:0]            fetch_pc,
    output logic                       fetch_ready,
    input  logic [REG_AW-1:0]          dec_src_a,
    input  logic [REG_AW-1:0]          dec_src_b,
    input  logic                       dec_use_a,
    input  logic                       dec_use_b,
    input  logic [REG_AW-1:0]          dec_dst,
    input  logic                       dec_wr,
    input  logic                       hold,
    input  logic                       flush,
    output logic [DEPTH-1:0]           stage_valid,
    output logic [DEPTH*INSTR_W-1:0]   stage_instr,
    output logic [DEPTH*PC_W-1:0]      stage_pc,
    output logic [DEPTH-1:0]           stage_load,
    output logic                       hazard,
    output logic                       halted,
    output logic [15:0]                perf_cycles,
    output logic [15:0]                perf_stalls,
    output logic [15:0]                perf_flush
);

    stage_t     st_q [DEPTH];
    stage_t     st_d [DEPTH];
    stage_act_e act  [DEPTH];
    logic       hazard_c;
    logic       stop_wb_c;
    logic       halted_q;
    logic       halted_d;

    // RAW check of the stage-1 reader against every older writer, writeback included.
    always_comb begin
        hazard_c = 1'b0;
        for (int unsigned k = 2; k < DEPTH; k++) begin
            if (st_q[k].valid && st_q[k].wr &&
                ((dec_use_a && (st_q[k].dst == dec_src_a)) ||
                 (dec_use_b && (st_q[k].dst == dec_src_b)))) begin
                hazard_c = 1'b1;
            end
        end
        hazard_c = hazard_c & st_q[1].valid;
    end

    // Upstream payloads; decode results join the instruction on its way into stage 2.
    always_comb begin
        st_d[0]       = '0;
        st_d[0].valid = fetch_valid;
        st_d[0].instr = fetch_instr;
        st_d[0].pc    = fetch_pc;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            st_d[k] = st_q[k-1];
        end
        st_d[2].dst = dec_dst;
        st_d[2].wr  = dec_wr & st_q[1].valid;
    end

    // Priority decoder: halted > hold > flush > hazard > advance.
    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            act[k] = ACT_HOLD;
        end
        if (!halted_q && !hold) begin
            if (flush) begin
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    act[k] = (k < BR_STAGE) ? ACT_BUBBLE : ACT_LOAD;
                end
            end else if (hazard_c) begin
                for (int unsigned k = 2; k < DEPTH; k++) begin
                    act[k] = (k == 2) ? ACT_BUBBLE : ACT_LOAD;
                end
            end else begin
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    act[k] = ACT_LOAD;
                end
                if (!fetch_valid) begin
                    act[0] = ACT_BUBBLE;
                end
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_stage_reg u_stage_reg (
            .clk   (clock),
            .rst_n (resetn),
            .act   (act[g]),
            .d     (st_d[g]),
            .q     (st_q[g])
        );
    end

    assign stop_wb_c = st_q[DEPTH-1].valid && (st_q[DEPTH-1].instr[3:0] == STOP_OP);
    assign halted_d  = halted_q | stop_wb_c;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
            stage_valid[k]                     = st_q[k].valid;
            stage_instr[k*INSTR_W +: INSTR_W]  = st_q[k].instr;
            stage_pc[k*PC_W +: PC_W]           = st_q[k].pc;
            stage_load[k]                      = act_loads(act[k]);
        end
    end

    assign hazard      = hazard_c;
    assign halted      = halted_q;
    assign fetch_ready = ~halted_q & ~hold & ~flush & ~hazard_c;

`ifdef PIPE_PERF_EN
    logic [15:0] cyc_q, cyc_d;
    logic [15:0] stall_q, stall_d;
    logic [15:0] flsh_q, flsh_d;

    // Saturating counters; stalls and flushes count only when they actually act.
    always_comb begin
        cyc_d   = cyc_q;
        stall_d = stall_q;
        flsh_d  = flsh_q;
        if (!halted_q && (cyc_q != 16'hFFFF)) begin
            cyc_d = cyc_q + 16'd1;
        end
        if (!halted_q && !hold && !flush && hazard_c && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
        if (!halted_q && !hold && flush && (flsh_q != 16'hFFFF)) begin
            flsh_d = flsh_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cyc_q   <= '0;
            stall_q <= '0;
            flsh_q  <= '0;
        end else begin
            cyc_q   <= cyc_d;
            stall_q <= stall_d;
            flsh_q  <= flsh_d;
        end
    end

    assign perf_cycles = cyc_q;
    assign perf_stalls = stall_q;
    assign perf_flush  = flsh_q;
`else
    assign perf_cycles = '0;
    assign perf_stalls = '0;
    assign perf_flush  = '0;
`endif

endmodule
